// File: rtl/arm_mem_pkg.sv
// Shared types for the M-stage data-memory responder and its write buffer.
// Holds the buffer entry layout, depth ceiling and the byte-lane helper.
package arm_mem_pkg;

    localparam int WB_DEPTH_MAX = 8;
    localparam int WIDX_W       = 30;

    typedef struct packed {
        logic [WIDX_W-1:0] widx;
        logic [31:0]       data;
        logic [3:0]        be;
    } wb_entry_t;

    function automatic logic [3:0] lane_sel(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

endpackage

// File: rtl/dmem_wb_fifo.sv
// Circular write buffer with head/tail pointers and an age-ordered entry view.
// o_ord[0] is the oldest entry; o_vld marks which slots of the view are live.
module dmem_wb_fifo
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  wb_entry_t               i_entry,
    input  logic                    i_pop,
    input  logic                    i_merge,
    input  logic [31:0]             i_mdata,
    input  logic [3:0]              i_mbe,
    output wb_entry_t               o_ord [WB_DEPTH_MAX],
    output logic [WB_DEPTH_MAX-1:0] o_vld,
    output wb_entry_t               o_head,
    output wb_entry_t               o_young,
    output logic [3:0]              o_count
);

    localparam logic [2:0] LAST = 3'(DEPTH - 1);

    wb_entry_t  r_mem [WB_DEPTH_MAX];
    logic [2:0] r_head;
    logic [2:0] r_tail;
    logic [3:0] r_count;
    logic [2:0] w_ytail;
    wb_entry_t  w_mrg;

    function automatic logic [2:0] nxt(input logic [2:0] p);
        return (p == LAST) ? 3'd0 : p + 3'd1;
    endfunction

    assign w_ytail = (r_tail == 3'd0) ? LAST : r_tail - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= nxt(r_tail);
            if (i_pop)  r_head <= nxt(r_head);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload carries no reset; liveness is defined by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push)  r_mem[r_tail]  <= i_entry;
        if (i_merge) r_mem[w_ytail] <= w_mrg;
    end

    always_comb begin
        w_mrg    = r_mem[w_ytail];
        w_mrg.be = w_mrg.be | i_mbe;
        for (int l = 0; l < 4; l++) begin
            if (i_mbe[l]) w_mrg.data[8*l +: 8] = i_mdata[8*l +: 8];
        end
    end

    always_comb begin
        logic [3:0] pos;
        pos   = '0;
        o_vld = '0;
        for (int i = 0; i < WB_DEPTH_MAX; i++) begin
            pos = {1'b0, r_head} + 4'(i);
            if (pos > {1'b0, LAST}) pos = pos - 4'(DEPTH);
            o_ord[i] = r_mem[pos[2:0]];
            o_vld[i] = (4'(i) < r_count);
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_young = r_mem[w_ytail];
    assign o_count = r_count;

endmodule

// File: rtl/dmem_wb_responder.sv
// M-stage data responder: word RAM behind a write buffer with load forwarding.
// Define WB_COALESCE_EN to merge stores into the youngest entry of the same word.
module dmem_wb_responder
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        byte_op,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [3:0]  wb_count,
    output logic        wb_empty
);

    logic [31:0]             r_ram [2**ADDR_W];
    wb_entry_t               w_ord [WB_DEPTH_MAX];
    logic [WB_DEPTH_MAX-1:0] w_vld;
    wb_entry_t               w_head;
    wb_entry_t               w_young;
    wb_entry_t               w_new;
    logic [ADDR_W-1:0]       w_ridx;
    logic [ADDR_W-1:0]       w_hidx;
    logic [WIDX_W-1:0]       w_widx;
    logic [1:0]              w_lane;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_drain;
    logic                    w_merge;
    logic                    w_push;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic                    w_unused;

    assign w_ridx = addr[ADDR_W+1:2];
    assign w_widx = {{(WIDX_W-ADDR_W){1'b0}}, w_ridx};
    assign w_lane = addr[1:0];
    assign w_hidx = w_head.widx[ADDR_W-1:0];

    assign w_full   = (wb_count == 4'(WB_DEPTH));
    assign stall    = w_full & (we | re);
    assign w_accept = we & ~stall;
    assign w_drain  = ~wb_empty & (~re | w_full);
    assign wb_empty = (wb_count == 4'd0);

    assign w_new.widx = w_widx;
    assign w_new.data = byte_op ? {4{wdata[7:0]}} : wdata;
    assign w_new.be   = byte_op ? lane_sel(w_lane) : 4'hF;

`ifdef WB_COALESCE_EN
    // A single remaining head is leaving this edge, so it cannot absorb the store.
    assign w_merge = w_accept & ~wb_empty
                   & (w_young.widx == w_widx)
                   & ~(w_drain & (wb_count == 4'd1));
    assign w_unused = &{1'b0, addr[31:ADDR_W+2],
                        w_head.widx[WIDX_W-1:ADDR_W]};
`else
    assign w_merge  = 1'b0;
    assign w_unused = &{1'b0, addr[31:ADDR_W+2],
                        w_head.widx[WIDX_W-1:ADDR_W], w_young};
`endif

    assign w_push = w_accept & ~w_merge;

    dmem_wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_entry (w_new),
        .i_pop   (w_drain),
        .i_merge (w_merge),
        .i_mdata (w_new.data),
        .i_mbe   (w_new.be),
        .o_ord   (w_ord),
        .o_vld   (w_vld),
        .o_head  (w_head),
        .o_young (w_young),
        .o_count (wb_count)
    );

    always_ff @(posedge clk) begin
        if (w_drain) begin
            for (int l = 0; l < 4; l++) begin
                if (w_head.be[l])
                    r_ram[w_hidx][8*l +: 8] <= w_head.data[8*l +: 8];
            end
        end
    end

    // Oldest to youngest, so the youngest matching lane wins.
    always_comb begin
        w_word = r_ram[w_ridx];
        for (int i = 0; i < WB_DEPTH_MAX; i++) begin
            for (int l = 0; l < 4; l++) begin
                if (w_vld[i] && (w_ord[i].widx == w_widx) && w_ord[i].be[l])
                    w_word[8*l +: 8] = w_ord[i].data[8*l +: 8];
            end
        end
    end

    assign w_byte = w_word[8*w_lane +: 8];
    assign rdata  = (re & byte_op) ? {24'h0, w_byte} : w_word;

endmodule

// File: tb/tb_dmem_wb_responder.sv
// Directed bench for dmem_wb_responder; each task checks one scenario inline.
// Expected coalescing results follow WB_COALESCE_EN when it is defined.
module tb_dmem_wb_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        byte_op;
    logic [31:0] rdata;
    logic        stall;
    logic [3:0]  wb_count;
    logic        wb_empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_wb_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .byte_op  (byte_op),
        .rdata    (rdata),
        .stall    (stall),
        .wb_count (wb_count),
        .wb_empty (wb_empty)
    );

    task automatic drive(input logic w, input logic r, input logic b,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; re = r; byte_op = b; addr = a; wdata = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0);
        n_run++;
        if (wb_count !== 4'd0 || wb_empty !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: count=%0d empty=%b stall=%b exp 0/1/0",
                     wb_count, wb_empty, stall);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h500 + 32'(4*i), 32'(i));
            tick();
        end
        n_run++;
        if (wb_count !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_fill: count=%0d exp 3", wb_count);
        end
        drive(0, 1, 0, 32'h500, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        n_run++;
        if (wb_count !== 4'd0 || wb_empty !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d empty=%b stall=%b exp 0/1/0",
                     wb_count, wb_empty, stall);
        end
        #2;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_store_fwd();
        drive(1, 0, 0, 32'h40, 32'hDEADBEEF);
        tick();
        drive(0, 1, 0, 32'h40, 32'h0);
        n_run++;
        if (rdata !== 32'hDEADBEEF || wb_count !== 4'd1) begin
            n_fail++;
            $display("FAIL fwd_word: rdata=%h count=%0d exp deadbeef/1",
                     rdata, wb_count);
        end
        tick();
        n_run++;
        if (wb_count !== 4'd1) begin
            n_fail++;
            $display("FAIL fwd_hold: count=%0d exp 1", wb_count);
        end
        idle(1);
        n_run++;
        if (wb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_drain: empty=%b exp 1", wb_empty);
        end
    endtask

    task automatic test_byte_merge();
        drive(1, 0, 0, 32'h80, 32'h11223344);
        tick();
        idle(1);
        drive(1, 0, 1, 32'h82, 32'h000000AA);
        tick();
        drive(0, 1, 0, 32'h80, 32'h0);
        n_run++;
        if (rdata !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL byte_fwd_word: rdata=%h exp 11aa3344", rdata);
        end
        drive(0, 1, 1, 32'h82, 32'h0);
        n_run++;
        if (rdata !== 32'h000000AA) begin
            n_fail++;
            $display("FAIL byte_fwd_ldrb: rdata=%h exp 000000aa", rdata);
        end
        idle(2);
        drive(0, 1, 0, 32'h80, 32'h0);
        n_run++;
        if (rdata !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL byte_ram_word: rdata=%h exp 11aa3344", rdata);
        end
        drive(0, 1, 1, 32'h83, 32'h0);
        n_run++;
        if (rdata !== 32'h00000011) begin
            n_fail++;
            $display("FAIL byte_ram_ldrb: rdata=%h exp 00000011", rdata);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 0, 32'h0000_1040, 32'h0);
        n_run++;
        if (rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wrap_index: rdata=%h exp deadbeef", rdata);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 0, 32'h80, 32'h55555555);
        n_run++;
        if (rdata !== 32'h11AA3344 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old: rdata=%h stall=%b exp 11aa3344/0",
                     rdata, stall);
        end
        tick();
        drive(0, 1, 0, 32'h80, 32'h0);
        n_run++;
        if (rdata !== 32'h55555555) begin
            n_fail++;
            $display("FAIL same_cycle_new: rdata=%h exp 55555555", rdata);
        end
        idle(2);
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 32'h200 + 32'(4*i), 32'h1000_0000 + 32'(i));
            tick();
        end
        n_run++;
        if (wb_count !== 4'd4) begin
            n_fail++;
            $display("FAIL full_fill: count=%0d exp 4", wb_count);
        end
        drive(1, 1, 0, 32'h210, 32'h77777777);
        n_run++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall: stall=%b exp 1", stall);
        end
        tick();
        n_run++;
        if (wb_count !== 4'd3 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: count=%0d stall=%b exp 3/0",
                     wb_count, stall);
        end
        tick();
        n_run++;
        if (wb_count !== 4'd4) begin
            n_fail++;
            $display("FAIL full_retry: count=%0d exp 4", wb_count);
        end
        idle(4);
        n_run++;
        if (wb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_empty: empty=%b exp 1", wb_empty);
        end
        drive(0, 1, 0, 32'h20C, 32'h0);
        n_run++;
        if (rdata !== 32'h1000_0003) begin
            n_fail++;
            $display("FAIL full_ram_20c: rdata=%h exp 10000003", rdata);
        end
        drive(0, 1, 0, 32'h210, 32'h0);
        n_run++;
        if (rdata !== 32'h77777777) begin
            n_fail++;
            $display("FAIL full_ram_210: rdata=%h exp 77777777", rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 32'h300, 32'hCAFEF00D);
        tick();
        drive(1, 0, 0, 32'h304, 32'h0BADC0DE);
        tick();
        n_run++;
        if (wb_count !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_acc_drain: count=%0d exp 1", wb_count);
        end
        idle(2);
        n_run++;
        if (wb_empty !== 1'b1 || wb_count !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_empty: empty=%b count=%0d exp 1/0",
                     wb_empty, wb_count);
        end
        drive(0, 1, 0, 32'h300, 32'h0);
        n_run++;
        if (rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL b2b_ram_300: rdata=%h exp cafef00d", rdata);
        end
        drive(0, 1, 0, 32'h304, 32'h0);
        n_run++;
        if (rdata !== 32'h0BADC0DE) begin
            n_fail++;
            $display("FAIL b2b_ram_304: rdata=%h exp 0badc0de", rdata);
        end
    endtask

    task automatic test_coalesce();
        logic [3:0] exp_cnt;
`ifdef WB_COALESCE_EN
        exp_cnt = 4'd1;
`else
        exp_cnt = 4'd2;
`endif
        drive(1, 0, 0, 32'h100, 32'hA5A5FFFF);
        tick();
        idle(1);
        drive(1, 1, 1, 32'h100, 32'h01);
        tick();
        drive(1, 1, 1, 32'h101, 32'h02);
        tick();
        n_run++;
        if (wb_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL coal_count: count=%0d exp %0d", wb_count, exp_cnt);
        end
        drive(0, 1, 0, 32'h100, 32'h0);
        n_run++;
        if (rdata !== 32'hA5A50201) begin
            n_fail++;
            $display("FAIL coal_word: rdata=%h exp a5a50201", rdata);
        end
        drive(0, 1, 1, 32'h101, 32'h0);
        n_run++;
        if (rdata !== 32'h00000002) begin
            n_fail++;
            $display("FAIL coal_ldrb: rdata=%h exp 00000002", rdata);
        end
        idle(3);
        drive(0, 1, 0, 32'h100, 32'h0);
        n_run++;
        if (rdata !== 32'hA5A50201 || wb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL coal_ram: rdata=%h empty=%b exp a5a50201/1",
                     rdata, wb_empty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_fwd();
        test_byte_merge();
        test_wrap();
        test_same_cycle();
        test_full();
        test_back_to_back();
        test_coalesce();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
